// File: rtl/preg_free_list_pkg.sv
// Shared types and constants for the physical-register free list.
// Sizes derive from the PReg/AReg counts so the FIFO tracks the rename geometry.
package preg_free_list_pkg;

    localparam int NUM_PREGS    = 64;
    localparam int NUM_AREGS    = 32;
    localparam int RENAME_WIDTH = 2;
    localparam int FL_DEPTH     = NUM_PREGS - NUM_AREGS;
    localparam int PREG_W       = $clog2(NUM_PREGS);
    localparam int FL_CNT_W     = $clog2(FL_DEPTH + 1);
    localparam int FL_PTR_W     = $clog2(FL_DEPTH);

    typedef logic [PREG_W-1:0]   p_reg;
    typedef logic [FL_CNT_W-1:0] free_list_count;
    typedef logic [FL_PTR_W-1:0] fl_ptr;

    // Accepted retire lanes packed to the front, ready to be written at tail.
    typedef struct packed {
        logic [1:0] n;
        p_reg       id1;
        p_reg       id0;
    } free_pack_t;

    // Pointer advance modulo FL_DEPTH, valid for any depth (not only powers of two).
    function automatic fl_ptr ptr_add(input fl_ptr p, input logic [1:0] n);
        logic [FL_PTR_W:0] s;
        s = {1'b0, p} + {{(FL_PTR_W-1){1'b0}}, n};
        if (s >= (FL_PTR_W+1)'(FL_DEPTH))
            s = s - (FL_PTR_W+1)'(FL_DEPTH);
        return s[FL_PTR_W-1:0];
    endfunction

endpackage

// File: rtl/preg_free_list.sv
// Circular FIFO of free physical register IDs: peeks up to two grants per cycle for
// rename and reclaims up to two stale PRegs per cycle from retire.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [0:1]                 i_alloc_req,
    output logic [0:1][PREG_W-1:0]     o_free_pregs,
    output logic                       o_alloc_ok,
    input  logic [0:1]                 i_free_en,
    input  logic [0:1][PREG_W-1:0]     i_free_preg,
    output logic [FL_CNT_W-1:0]        o_count,
    output logic                       o_empty,
    output logic                       o_overflow
);

    p_reg           mem [FL_DEPTH];
    fl_ptr          head;
    fl_ptr          tail;
    free_list_count count;
    logic           overflow;

    logic [1:0]     n_req;
    logic [1:0]     n_alloc;
    free_list_count room;
    logic           valid0, valid1;
    logic           keep0, keep1;
    logic           drop;
    free_pack_t     pack;

    function automatic free_pack_t compact_lanes(input logic k0, input logic k1,
                                                 input p_reg p0, input p_reg p1);
        free_pack_t r;
        r.n   = {1'b0, k0} + {1'b0, k1};
        r.id0 = k0 ? p0 : p1;
        r.id1 = p1;
        return r;
    endfunction

    // Grant is all-or-nothing; frees see only the room left after this cycle's allocation.
    always_comb begin
        n_req      = {1'b0, i_alloc_req[0]} + {1'b0, i_alloc_req[1]};
        o_alloc_ok = (count >= free_list_count'(n_req));
        n_alloc    = o_alloc_ok ? n_req : 2'd0;
        room       = free_list_count'(FL_DEPTH) - (count - free_list_count'(n_alloc));
        valid0     = i_free_en[0] && (i_free_preg[0] != '0);
        valid1     = i_free_en[1] && (i_free_preg[1] != '0);
        keep0      = valid0 && (room != '0);
        keep1      = valid1 && (keep0 ? (room >= free_list_count'(2)) : (room != '0));
        drop       = (valid0 && !keep0) || (valid1 && !keep1);
        pack       = compact_lanes(keep0, keep1, i_free_preg[0], i_free_preg[1]);
    end

    // Lane 1 peeks one slot further only when lane 0 also consumes one.
    always_comb begin
        o_free_pregs[0] = mem[head];
        o_free_pregs[1] = mem[ptr_add(head, {1'b0, i_alloc_req[0]})];
        o_count         = count;
        o_empty         = (count == '0);
        o_overflow      = overflow;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < FL_DEPTH; k++)
                mem[k] <= p_reg'(NUM_AREGS + k);
            head     <= '0;
            tail     <= '0;
            count    <= free_list_count'(FL_DEPTH);
            overflow <= 1'b0;
        end else begin
            if (pack.n != 2'd0)
                mem[tail] <= pack.id0;
            if (pack.n == 2'd2)
                mem[ptr_add(tail, 2'd1)] <= pack.id1;
            head     <= ptr_add(head, n_alloc);
            tail     <= ptr_add(tail, pack.n);
            count    <= count - free_list_count'(n_alloc) + free_list_count'(pack.n);
            overflow <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Randomised bench for preg_free_list against a queue-based model of the free pool.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [0:1]             alloc_req = '0;
    logic [0:1][PREG_W-1:0] free_pregs;
    logic                   alloc_ok;
    logic [0:1]             free_en = '0;
    logic [0:1][PREG_W-1:0] free_preg = '0;
    logic [FL_CNT_W-1:0]    count;
    logic                   empty;
    logic                   overflow;

    int checks = 0;
    int errors = 0;
    int model_q[$];
    bit model_ovf;

    preg_free_list dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_alloc_req  (alloc_req),
        .o_free_pregs (free_pregs),
        .o_alloc_ok   (alloc_ok),
        .i_free_en    (free_en),
        .i_free_preg  (free_preg),
        .o_count      (count),
        .o_empty      (empty),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        for (int k = 0; k < FL_DEPTH; k++)
            model_q.push_back(NUM_AREGS + k);
        model_ovf = 1'b0;
    endtask

    // Expected outputs follow from the pool contents and the requests currently driven.
    task automatic compareState(input string tag);
        int n;
        int idx;
        n = int'(alloc_req[0]) + int'(alloc_req[1]);
        checkOutput({tag, ".count"}, 32'(count), model_q.size());
        checkOutput({tag, ".empty"}, 32'(empty), (model_q.size() == 0) ? 1 : 0);
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(model_ovf));
        checkOutput({tag, ".alloc_ok"}, 32'(alloc_ok), (model_q.size() >= n) ? 1 : 0);
        if (model_q.size() > 0)
            checkOutput({tag, ".peek0"}, 32'(free_pregs[0]), model_q[0]);
        idx = alloc_req[0] ? 1 : 0;
        if (model_q.size() > idx)
            checkOutput({tag, ".peek1"}, 32'(free_pregs[1]), model_q[idx]);
    endtask

    // Called just after a rising edge: drive, compare mid-cycle, then advance the model.
    task automatic applyStimulus(input bit r0, input bit r1, input bit f0, input bit f1,
                                 input int p0, input int p1, input string tag);
        int n;
        alloc_req    = {r0, r1};
        free_en      = {f0, f1};
        free_preg[0] = PREG_W'(p0);
        free_preg[1] = PREG_W'(p1);
        @(negedge clk);
        compareState(tag);
        @(posedge clk);
        n = int'(r0) + int'(r1);
        if (model_q.size() >= n)
            for (int i = 0; i < n; i++) void'(model_q.pop_front());
        if (f0 && p0 != 0) begin
            if (model_q.size() < FL_DEPTH) model_q.push_back(p0);
            else model_ovf = 1'b1;
        end
        if (f1 && p1 != 0) begin
            if (model_q.size() < FL_DEPTH) model_q.push_back(p1);
            else model_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic resetDut(input string tag);
        alloc_req = '0;
        free_en   = '0;
        rst_n     = 1'b0;
        modelReset();
        #1;
        compareState(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int preq;
        int pfree;
        @(posedge clk);
        #1;
        resetDut("reset");

        for (int i = 0; i < 16; i++)
            applyStimulus(1, 1, 0, 0, 0, 0, "drain");
        applyStimulus(1, 1, 0, 0, 0, 0, "empty_req2");
        applyStimulus(0, 1, 0, 0, 0, 0, "empty_req1");
        applyStimulus(0, 0, 1, 1, 5, 9, "empty_free");
        applyStimulus(0, 1, 0, 0, 0, 0, "lane1_only");
        applyStimulus(1, 1, 0, 0, 0, 0, "one_left_req2");
        applyStimulus(1, 0, 1, 0, 7, 0, "alloc_free_same");
        applyStimulus(0, 0, 0, 0, 0, 0, "after_same");

        resetDut("reset2");
        applyStimulus(0, 0, 1, 1, 12, 13, "full_free");
        applyStimulus(0, 0, 1, 0, 0, 0, "sticky_ovf");
        applyStimulus(1, 0, 1, 1, 20, 21, "full_alloc1_free2");
        applyStimulus(1, 1, 1, 1, 0, 22, "free_p0");

        resetDut("reset3");
        for (int ph = 0; ph < 3; ph++) begin
            preq  = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
            pfree = (ph == 0) ? 25 : (ph == 1) ? 50 : 85;
            for (int c = 0; c < 400; c++) begin
                applyStimulus($urandom_range(99) < preq, $urandom_range(99) < preq,
                              $urandom_range(99) < pfree, $urandom_range(99) < pfree,
                              $urandom_range(NUM_PREGS-1), $urandom_range(NUM_PREGS-1),
                              "random");
                if (ph == 1 && c == 200)
                    resetDut("midreset");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
